// File: rtl/shader_pkg.sv
// Shared types for the shader program loader: instruction word and FSM states.
package shader_pkg;

  typedef logic [7:0] instr_t;

  localparam int NUM_INSTR_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    PENDING,
    LOAD
  } state_t;

endpackage

// File: rtl/spi_byte_rx.sv
// SPI slave byte receiver (CPOL=0, CPHA=1, MSB first) sampled in the pixel clock domain.
module spi_byte_rx
  import shader_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic   clk_i,
  input  logic   rst_i,
  input  logic   spi_sclk_i,
  input  logic   spi_mosi_i,
  input  logic   spi_cs_ni,
  output logic   byte_valid_o,
  output instr_t byte_data_o,
  output logic   cs_rise_o,
  output logic   cs_fall_o,
  output logic   partial_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;
  logic [2:0]             bit_cnt_q;
  instr_t                 shift_q;
  logic                   byte_valid_q;

  logic sclk_s, mosi_s, cs_s, sclk_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_fall = sclk_prev_q & ~sclk_s;

  // CS resets to its idle (high) level so reset release never fakes an edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_ni};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (cs_s) begin
        bit_cnt_q <= '0;
      end else if (sclk_fall) begin
        shift_q   <= {shift_q[6:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_valid_q <= 1'b1;
        end
      end
    end
  end

  assign byte_valid_o = byte_valid_q;
  assign byte_data_o  = shift_q;
  assign cs_rise_o    = cs_s & ~cs_prev_q;
  assign cs_fall_o    = ~cs_s & cs_prev_q;
  // Bit count still holds the trailing bits during the CS rise cycle.
  assign partial_o    = (bit_cnt_q != 3'd0);

endmodule

// File: rtl/shader_load_ctrl.sv
// Stages a full shader program received over SPI and bursts it into shader memory
// at the next vblank rising edge, so a frame never runs a mixed program.
module shader_load_ctrl
  import shader_pkg::*;
#(
  parameter int NUM_INSTR   = NUM_INSTR_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_sclk_i,
  input  logic       spi_mosi_i,
  input  logic       spi_cs_ni,
  input  logic       vblank_i,
  output logic       mem_load_o,
  output logic [7:0] mem_instr_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam int IDX_W = $clog2(NUM_INSTR);
  localparam int CNT_W = $clog2(NUM_INSTR + 1);

  logic   byte_valid, cs_rise, cs_fall, partial;
  instr_t byte_data;

  spi_byte_rx #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .spi_sclk_i   (spi_sclk_i),
    .spi_mosi_i   (spi_mosi_i),
    .spi_cs_ni    (spi_cs_ni),
    .byte_valid_o (byte_valid),
    .byte_data_o  (byte_data),
    .cs_rise_o    (cs_rise),
    .cs_fall_o    (cs_fall),
    .partial_o    (partial)
  );

  instr_t           staging_q [NUM_INSTR];
  logic [CNT_W-1:0] byte_cnt_q;
  logic             overflow_q;
  logic             frame_acc_q;
  logic             vblank_q;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             mem_load_q, mem_load_d;
  instr_t           mem_instr_q, mem_instr_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic frame_ok, vblank_rise, stage_wr;

  assign stage_wr    = byte_valid && frame_acc_q && (byte_cnt_q < CNT_W'(NUM_INSTR));
  assign frame_ok    = frame_acc_q && (byte_cnt_q == CNT_W'(NUM_INSTR)) && !overflow_q && !partial;
  assign vblank_rise = vblank_i && !vblank_q;

  always_ff @(posedge clk_i) begin
    if (stage_wr) begin
      staging_q[byte_cnt_q[IDX_W-1:0]] <= byte_data;
    end
  end

  // A frame only owns the staging buffer if it began while nothing was pending.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      byte_cnt_q  <= '0;
      overflow_q  <= 1'b0;
      frame_acc_q <= 1'b0;
      vblank_q    <= 1'b0;
    end else begin
      vblank_q <= vblank_i;
      if (cs_fall) begin
        byte_cnt_q  <= '0;
        overflow_q  <= 1'b0;
        frame_acc_q <= (state_q == IDLE);
      end else if (byte_valid) begin
        if (byte_cnt_q < CNT_W'(NUM_INSTR)) begin
          byte_cnt_q <= byte_cnt_q + CNT_W'(1);
        end else begin
          overflow_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      mem_load_q  <= 1'b0;
      mem_instr_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      mem_load_q  <= mem_load_d;
      mem_instr_q <= mem_instr_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    err_d   = cs_rise && !frame_ok;
    case (state_q)
      IDLE: begin
        if (cs_rise && frame_ok) begin
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (vblank_rise) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (idx_q == IDX_W'(NUM_INSTR - 1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so the burst starts the cycle after the edge.
    mem_load_d  = (state_d == LOAD);
    mem_instr_d = mem_load_d ? staging_q[idx_d] : mem_instr_q;
  end

  assign mem_load_o  = mem_load_q;
  assign mem_instr_o = mem_instr_q;
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
